// File: rtl/csa_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csa_add_sequencer
// Description : Shared multi-cycle adder. Two requesters are arbitrated
//               round-robin onto one 4-bit carry-select slice; a WIDTH-bit
//               add takes NSL slice cycles, LSB slice first, with the carry
//               held in a register between slices. Results (sum, carry-out,
//               signed overflow, requester id) leave on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_add_sequencer #(
  parameter int WIDTH = 16,  // multiple of SLICE, at least 8
  parameter int SLICE = 4    // fixed: matches the carry-select slice
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  localparam int NSL     = WIDTH / SLICE;
  localparam int c_IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NSL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_id;
  logic                 r_carry;
  logic [c_IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]     r_sum_work;
  logic                 r_last_grant;
  logic                 r_res_valid;
  logic [WIDTH-1:0]     r_res_sum;
  logic                 r_res_cout;
  logic                 r_res_ovf;
  logic                 r_res_id;

  logic                 w_idle;
  logic                 w_any_valid;
  logic                 w_grant_id;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_acc_a;
  logic [WIDTH-1:0]     w_acc_b;
  logic                 w_acc_cin;
  logic [SLICE-1:0]     w_a_sl;
  logic [SLICE-1:0]     w_b_sl;
  logic [SLICE:0]       w_res_c0;
  logic [SLICE:0]       w_res_c1;
  logic [SLICE:0]       w_res_sel;
  logic [SLICE-1:0]     w_sel_sum;
  logic                 w_sel_cout;
  logic                 w_msb_cin;
  logic [WIDTH-1:0]     w_sum_next;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign w_idle      = (r_state == S_IDLE);
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign req0_ready  = w_idle & w_any_valid & ~w_grant_id;
  assign req1_ready  = w_idle & w_any_valid &  w_grant_id;
  assign w_accept    = req0_ready | req1_ready;

  assign w_acc_a   = w_grant_id ? req1_a   : req0_a;
  assign w_acc_b   = w_grant_id ? req1_b   : req0_b;
  assign w_acc_cin = w_grant_id ? req1_cin : req0_cin;

  // Carry-select slice: both carry-in hypotheses are formed in parallel and
  // the registered carry picks one, so the slice never ripples the carry in.
  assign w_a_sl     = r_a[r_idx*SLICE +: SLICE];
  assign w_b_sl     = r_b[r_idx*SLICE +: SLICE];
  assign w_res_c0   = {1'b0, w_a_sl} + {1'b0, w_b_sl};
  assign w_res_c1   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(1);
  assign w_res_sel  = r_carry ? w_res_c1 : w_res_c0;
  assign w_sel_sum  = w_res_sel[SLICE-1:0];
  assign w_sel_cout = w_res_sel[SLICE];

  // Carry into the top bit of the current slice, recovered from its sum bit;
  // only meaningful on the final slice where it feeds the overflow flag.
  assign w_msb_cin = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sel_sum[SLICE-1];

  // Partial sum with the current slice merged in.
  always_comb begin
    w_sum_next = r_sum_work;
    w_sum_next[r_idx*SLICE +: SLICE] = w_sel_sum;
  end

  // Sequencer: accept in IDLE, one slice per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_carry      <= 1'b0;
      r_idx        <= '0;
      r_sum_work   <= '0;
      r_last_grant <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_sum    <= '0;
      r_res_cout   <= 1'b0;
      r_res_ovf    <= 1'b0;
      r_res_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_acc_a;
            r_b          <= w_acc_b;
            r_id         <= w_grant_id;
            r_carry      <= w_acc_cin;
            r_idx        <= '0;
            r_sum_work   <= '0;
            r_last_grant <= w_grant_id;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum_work <= w_sum_next;
          r_carry    <= w_sel_cout;
          r_idx      <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_res_sum   <= w_sum_next;
            r_res_cout  <= w_sel_cout;
            r_res_ovf   <= w_msb_cin ^ w_sel_cout;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_ovf   = r_res_ovf;
  assign res_id    = r_res_id;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
